// File: rtl/fp_divider.sv
// Sequential restoring radix-2 fixed-point divider: result = (a << FP_POSITIONS) / b,
// one quotient bit per cycle, truncation toward zero, saturation on overflow and b == 0.
module fp_divider #(
  parameter int SIGN         = 1,
  parameter int WIDTH        = 8,
  parameter int FP_POSITIONS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             div_by_zero
);

  localparam int N  = WIDTH + FP_POSITIONS;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0]    LAST     = CW'(N);
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
  localparam logic [N-1:0]     POS_LIM  = N'((2 ** (WIDTH - 1)) - 1);
  localparam logic [N-1:0]     NEG_LIM  = N'(2 ** (WIDTH - 1));
  localparam logic [N-1:0]     UNS_LIM  = N'((2 ** WIDTH) - 1);
  localparam logic [WIDTH-1:0] MAX_POS  = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] W_ONE    = WIDTH'(1);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t           state_r, state_s;
  logic [CW-1:0]    cnt_r;
  logic [N-1:0]     dvd_r, quo_r;
  logic [WIDTH-1:0] rem_r, dvs_r;
  logic             neg_r, a_neg_r, bzero_r;
  logic             accept_s, ge_s;
  logic [WIDTH:0]   trial_s;
  logic [WIDTH-1:0] diff_s, res_s;
  logic             ovf_s, dbz_s;

  // Magnitude of an operand; the most negative value maps to 2^(WIDTH-1) unsigned.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    if ((SIGN != 0) && v[WIDTH-1]) mag = ~v + W_ONE;
    else                           mag = v;
  endfunction

  assign accept_s = in_valid && in_ready;

  // One restoring step; the remainder stays below the divisor, so WIDTH bits of difference suffice.
  always_comb begin
    trial_s = {rem_r, dvd_r[N-1]};
    ge_s    = (trial_s >= {1'b0, dvs_r});
    diff_s  = trial_s[WIDTH-1:0] - dvs_r;
  end

  // Output stage: sign restoration and saturation of the N-bit quotient.
  always_comb begin
    res_s = quo_r[WIDTH-1:0];
    ovf_s = 1'b0;
    dbz_s = 1'b0;
    if (bzero_r) begin
      dbz_s = 1'b1;
      if (SIGN != 0) res_s = a_neg_r ? MIN_NEG : MAX_POS;
      else           res_s = ALL_ONES;
    end else if (SIGN != 0) begin
      if (!neg_r) begin
        if (quo_r > POS_LIM) begin
          res_s = MAX_POS;
          ovf_s = 1'b1;
        end else begin
          res_s = quo_r[WIDTH-1:0];
        end
      end else begin
        if (quo_r > NEG_LIM) begin
          res_s = MIN_NEG;
          ovf_s = 1'b1;
        end else begin
          res_s = ~quo_r[WIDTH-1:0] + W_ONE;
        end
      end
    end else begin
      if (quo_r > UNS_LIM) begin
        res_s = ALL_ONES;
        ovf_s = 1'b1;
      end else begin
        res_s = quo_r[WIDTH-1:0];
      end
    end
  end

  // Next-state logic; BUSY spends N iteration cycles plus one output-stage cycle.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    if (accept_s) state_s = BUSY; else state_s = IDLE;
      BUSY:    if (cnt_r == LAST) state_s = DONE; else state_s = BUSY;
      DONE:    if (out_ready) state_s = IDLE; else state_s = DONE;
      default: state_s = IDLE;
    endcase
  end

  // State register with handshake flags registered from the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state_r   <= state_s;
      in_ready  <= (state_s == IDLE);
      out_valid <= (state_s == DONE);
    end
  end

  // Datapath: operand capture, iteration, and result registration.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r       <= '0;
      dvd_r       <= '0;
      quo_r       <= '0;
      rem_r       <= '0;
      dvs_r       <= '0;
      neg_r       <= 1'b0;
      a_neg_r     <= 1'b0;
      bzero_r     <= 1'b0;
      result      <= '0;
      overflow    <= 1'b0;
      div_by_zero <= 1'b0;
    end else if (accept_s) begin
      cnt_r   <= '0;
      dvd_r   <= {mag(a), {FP_POSITIONS{1'b0}}};
      quo_r   <= '0;
      rem_r   <= '0;
      dvs_r   <= mag(b);
      neg_r   <= (SIGN != 0) && (a[WIDTH-1] ^ b[WIDTH-1]);
      a_neg_r <= (SIGN != 0) && a[WIDTH-1];
      bzero_r <= (b == '0);
    end else if (state_r == BUSY) begin
      if (cnt_r != LAST) begin
        cnt_r <= cnt_r + CNT_ONE;
        dvd_r <= {dvd_r[N-2:0], 1'b0};
        quo_r <= {quo_r[N-2:0], ge_s};
        rem_r <= ge_s ? diff_s : trial_s[WIDTH-1:0];
      end else begin
        result      <= res_s;
        overflow    <= ovf_s;
        div_by_zero <= dbz_s;
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: tb/tb_fp_divider.sv
// Scoreboard bench for fp_divider in Q4.4: signed instance checked by a queue-driven monitor,
// plus an unsigned instance for the SIGN=0 cases.
module tb_fp_divider;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, in_valid, in_ready, out_valid, out_ready, overflow, div_by_zero;
  logic [7:0] a, b, result;
  logic       u_in_valid, u_in_ready, u_out_valid, u_out_ready, u_overflow, u_div_by_zero;
  logic [7:0] u_a, u_b, u_result;

  fp_divider #(.SIGN(1), .WIDTH(8), .FP_POSITIONS(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .overflow(overflow), .div_by_zero(div_by_zero));

  fp_divider #(.SIGN(0), .WIDTH(8), .FP_POSITIONS(4)) dut_u (
    .clk(clk), .rst_n(rst_n), .in_valid(u_in_valid), .in_ready(u_in_ready), .a(u_a), .b(u_b),
    .out_valid(u_out_valid), .out_ready(u_out_ready), .result(u_result),
    .overflow(u_overflow), .div_by_zero(u_div_by_zero));

  typedef struct {
    logic [7:0] res;
    logic       ovf;
    logic       dbz;
    int         acc;
  } exp_t;

  exp_t sb[$];
  int   nchk = 0;
  int   nerr = 0;
  int   cyc  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops an expectation when out_valid rises, then checks it stays stable until taken.
  exp_t       cur;
  bit         seen = 1'b0;
  logic [7:0] h_res;
  logic       h_ovf, h_dbz;
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      check("in_ready_low_in_done", in_ready, 0);
      if (!seen) begin
        seen = 1'b1;
        if (sb.size() == 0) begin
          check("unexpected_output", 1, 0);
        end else begin
          cur = sb.pop_front();
          check("latency", cyc - cur.acc, 13);
          check("result", result, cur.res);
          check("overflow", overflow, cur.ovf);
          check("div_by_zero", div_by_zero, cur.dbz);
        end
        h_res = result;
        h_ovf = overflow;
        h_dbz = div_by_zero;
      end else begin
        check("hold_result", result, h_res);
        check("hold_flags", {overflow, div_by_zero}, {h_ovf, h_dbz});
      end
      if (out_ready) seen = 1'b0;
    end else begin
      seen = 1'b0;
    end
  end

  task automatic send(input logic [7:0] va, input logic [7:0] vb,
                      input logic [7:0] er, input logic eo, input logic ed);
    exp_t e;
    int   t = 0;
    a = va; b = vb; in_valid = 1'b1;
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      check("accept_timeout", 0, 1);
    end else begin
      e.res = er; e.ovf = eo; e.dbz = ed; e.acc = cyc + 1;
      sb.push_back(e);
    end
    @(negedge clk);
    in_valid = 1'b0; a = 8'h00; b = 8'h00;
  endtask

  task automatic drain();
    int t = 0;
    while ((sb.size() != 0 || !in_ready) && t < 300) begin
      @(negedge clk);
      t++;
    end
    check("drain_timeout", (sb.size() == 0) && in_ready, 1);
  endtask

  task automatic usend(input logic [7:0] va, input logic [7:0] vb,
                       input logic [7:0] er, input logic eo, input logic ed);
    int acc;
    int t = 0;
    u_a = va; u_b = vb; u_in_valid = 1'b1;
    check("u_in_ready", u_in_ready, 1);
    @(negedge clk);
    u_in_valid = 1'b0;
    acc = cyc;
    while (!u_out_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("u_latency", cyc - acc, 13);
    check("u_result", u_result, er);
    check("u_flags", {u_overflow, u_div_by_zero}, {eo, ed});
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = 8'h00; b = 8'h00;
    u_in_valid = 1'b0; u_out_ready = 1'b1; u_a = 8'h00; u_b = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_flags", {overflow, div_by_zero}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    send(8'h20, 8'h08, 8'h40, 1'b0, 1'b0);
    send(8'hE8, 8'h08, 8'hD0, 1'b0, 1'b0);
    send(8'h10, 8'h30, 8'h05, 1'b0, 1'b0);
    send(8'hF0, 8'h30, 8'hFB, 1'b0, 1'b0);
    send(8'h70, 8'h01, 8'h7F, 1'b1, 1'b0);
    send(8'h80, 8'h01, 8'h80, 1'b1, 1'b0);
    send(8'h10, 8'h00, 8'h7F, 1'b0, 1'b1);
    send(8'hF0, 8'h00, 8'h80, 1'b0, 1'b1);
    send(8'h00, 8'hF0, 8'h00, 1'b0, 1'b0);
    send(8'hF8, 8'h10, 8'hF8, 1'b0, 1'b0);
    drain();

    // Backpressure: hold DONE for 5 cycles while offering an input that must be ignored.
    out_ready = 1'b0;
    send(8'h20, 8'h08, 8'h40, 1'b0, 1'b0);
    begin
      int t = 0;
      while (!out_valid && t < 100) begin
        @(negedge clk);
        t++;
      end
      check("bp_out_valid", out_valid, 1);
    end
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; a = 8'h70; b = 8'h01;
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    send(8'h10, 8'h30, 8'h05, 1'b0, 1'b0);
    send(8'hF0, 8'h30, 8'hFB, 1'b0, 1'b0);
    drain();

    // Reset mid-BUSY aborts the operation without producing an output.
    send(8'h70, 8'h01, 8'h7F, 1'b1, 1'b0);
    drain();
    send(8'h20, 8'h08, 8'h40, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_result", result, 0);
    check("mid_rst_flags", {overflow, div_by_zero}, 0);
    send(8'hE8, 8'h08, 8'hD0, 1'b0, 1'b0);
    drain();

    usend(8'hFF, 8'h01, 8'hFF, 1'b1, 1'b0);
    usend(8'h20, 8'h08, 8'h40, 1'b0, 1'b0);
    usend(8'hF0, 8'h30, 8'h50, 1'b0, 1'b0);
    usend(8'h10, 8'h00, 8'hFF, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
    $finish;
  end

endmodule
